mem_access: RTL

//  MA pipeline stage; consumes EX->MA bundle (cmd_ld_ma/cmd_st_ma/wbk_rd_reg_ma/rd_adr_ma/rd_data_ma/st_data_ma/ldst_code_ma).

---
 rtl/mem_access.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: MA pipeline stage. Drives the data bus with a req/ack handshake,
// steers byte lanes, formats load data, flags misaligned accesses and bus
// timeouts, and registers the result into the WB stage.
module mem_access #(
  parameter logic [7:0] BUS_TMO = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        ma_flush,
  output logic        ma_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [29:0] dbus_adr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] rd_data_wb,
  output logic        ma_misalign,
  output logic        ma_bus_err,
  output logic [31:0] ma_fault_adr
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [DW-1:0] ea_q;
  logic          ld_q;
  logic [2:0]    ld_code;
  logic          ld_wbk;
  logic [RW-1:0] ld_rd;

  logic          is_word;
  logic          is_half;
  logic          misalign_c;
  logic [3:0]    be_c;
  logic [DW-1:0] wdata_c;
  logic          tmo_hit;

  // Stall is a pure decode of the state flop.
  assign ma_stall = (state == BUSY);

  // Timeout fires on the BUSY edge that would bring the counter to the limit.
  assign tmo_hit = (BUS_TMO != 8'd0) && ((tmo_cnt + 8'd1) == BUS_TMO);

  // Select the lane and extend the read word according to the captured funct3.
  function automatic logic [DW-1:0] load_fmt(input logic [DW-1:0] w,
                                             input logic [2:0]    code,
                                             input logic [1:0]    lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    if (code[1])
      return w;
    else if (code[0])
      return code[2] ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      return code[2] ? {24'h000000, b} : {{24{b[7]}}, b};
  endfunction

  // Access size decode, misalign detection and byte-lane steering of the bundle.
  always_comb begin
    is_word    = 1'b0;
    is_half    = 1'b0;
    misalign_c = 1'b0;
    be_c       = 4'b0000;
    wdata_c    = '0;
    is_word    = ldst_code_ma[1];
    is_half    = !ldst_code_ma[1] && ldst_code_ma[0];
    misalign_c = (is_half && rd_data_ma[0]) ||
                 (is_word && (rd_data_ma[1:0] != 2'b00));
    if (is_word) begin
      be_c    = 4'b1111;
      wdata_c = st_data_ma;
    end else if (is_half) begin
      be_c    = rd_data_ma[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{st_data_ma[15:0]}};
    end else begin
      be_c    = 4'b0001 << rd_data_ma[1:0];
      wdata_c = {4{st_data_ma[7:0]}};
    end
  end

  // IDLE/BUSY state machine with all bus, writeback and fault outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      ea_q          <= '0;
      ld_q          <= 1'b0;
      ld_code       <= '0;
      ld_wbk        <= 1'b0;
      ld_rd         <= '0;
      dbus_req      <= 1'b0;
      dbus_we       <= 1'b0;
      dbus_adr      <= '0;
      dbus_be       <= '0;
      dbus_wdata    <= '0;
      wbk_rd_reg_wb <= 1'b0;
      rd_adr_wb     <= '0;
      rd_data_wb    <= '0;
      ma_misalign   <= 1'b0;
      ma_bus_err    <= 1'b0;
      ma_fault_adr  <= '0;
    end else begin
      wbk_rd_reg_wb <= 1'b0;
      ma_misalign   <= 1'b0;
      ma_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!ma_flush) begin
            if (cmd_ld_ma || cmd_st_ma) begin
              if (misalign_c) begin
                ma_misalign  <= 1'b1;
                ma_fault_adr <= rd_data_ma;
              end else begin
                state      <= BUSY;
                dbus_req   <= 1'b1;
                dbus_we    <= cmd_st_ma;
                dbus_adr   <= rd_data_ma[31:2];
                dbus_be    <= be_c;
                dbus_wdata <= wdata_c;
                tmo_cnt    <= '0;
                ea_q       <= rd_data_ma;
                ld_q       <= !cmd_st_ma;
                ld_code    <= ldst_code_ma;
                ld_wbk     <= wbk_rd_reg_ma;
                ld_rd      <= rd_adr_ma;
              end
            end else if (wbk_rd_reg_ma) begin
              wbk_rd_reg_wb <= 1'b1;
              rd_adr_wb     <= rd_adr_ma;
              rd_data_wb    <= rd_data_ma;
            end
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            state    <= IDLE;
            dbus_req <= 1'b0;
            if (ld_q) begin
              wbk_rd_reg_wb <= ld_wbk;
              rd_adr_wb     <= ld_rd;
              rd_data_wb    <= load_fmt(dbus_rdata, ld_code, ea_q[1:0]);
            end
          end else if (tmo_hit) begin
            state        <= IDLE;
            dbus_req     <= 1'b0;
            ma_bus_err   <= 1'b1;
            ma_fault_adr <= ea_q;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
